// File: rtl/fifo_ctrl_mem_if.sv
// Transaction-side bundle of the FIFO controller/memory block.
// Groups the request, monitor-status and pointer/data return signals.
interface fifo_ctrl_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PTR_SIZE   = 4
);

  logic                  trans_write;
  logic [DATA_WIDTH-1:0] trans_wdata;
  logic                  trans_read;
  logic                  full_ind;
  logic                  empty_ind;
  logic                  fifo_wenable;
  logic                  fifo_renable;
  logic [PTR_SIZE-1:0]   write_ptr;
  logic [PTR_SIZE-1:0]   read_ptr;
  logic [DATA_WIDTH-1:0] trans_rdata;
  logic                  trans_rvalid;
  logic [PTR_SIZE-1:0]   fill_level;

  modport master (
    output trans_write,
    output trans_wdata,
    output trans_read,
    output full_ind,
    output empty_ind,
    input  fifo_wenable,
    input  fifo_renable,
    input  write_ptr,
    input  read_ptr,
    input  trans_rdata,
    input  trans_rvalid,
    input  fill_level
  );

  modport slave (
    input  trans_write,
    input  trans_wdata,
    input  trans_read,
    input  full_ind,
    input  empty_ind,
    output fifo_wenable,
    output fifo_renable,
    output write_ptr,
    output read_ptr,
    output trans_rdata,
    output trans_rvalid,
    output fill_level
  );

endinterface

// File: rtl/fifo_ctrl_mem.sv
// FIFO pointer control plus storage array with registered read port.
// Full/empty come from the external monitor stage; no internal error flags.
module fifo_ctrl_mem #(
  parameter int OSTD_NUM   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int PTR_SIZE   = $clog2(OSTD_NUM) + 1
) (
  input  logic             clk_in,
  input  logic             areset_b,
  fifo_ctrl_mem_if.slave   bus
);

  localparam int AW = PTR_SIZE - 1;
  localparam logic [PTR_SIZE-1:0] FULL_LVL = PTR_SIZE'(OSTD_NUM);
  localparam logic [PTR_SIZE-1:0] ONE      = PTR_SIZE'(1);

  logic [DATA_WIDTH-1:0] mem_q [OSTD_NUM];

  logic                  ren;
  logic                  wen;

  logic [PTR_SIZE-1:0]   wr_ptr_q;
  logic [PTR_SIZE-1:0]   wr_ptr_d;
  logic [PTR_SIZE-1:0]   rd_ptr_q;
  logic [PTR_SIZE-1:0]   rd_ptr_d;
  logic [PTR_SIZE-1:0]   fill_q;
  logic [PTR_SIZE-1:0]   fill_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  rvalid_q;
  logic                  rvalid_d;

  // Reset gates the enables so nothing is accepted while held in reset.
  assign ren = bus.trans_read & ~bus.empty_ind & areset_b;
  assign wen = bus.trans_write & (~bus.full_ind | ren) & areset_b;

  assign bus.fifo_renable = ren;
  assign bus.fifo_wenable = wen;
  assign bus.write_ptr    = wr_ptr_q;
  assign bus.read_ptr     = rd_ptr_q;
  assign bus.fill_level   = fill_q;
  assign bus.trans_rdata  = rdata_q;
  assign bus.trans_rvalid = rvalid_q;

  // Storage is not reset; the pointers alone define valid contents.
  always_ff @(posedge clk_in) begin
    if (wen) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.trans_wdata;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    rdata_d  = rdata_q;
    rvalid_d = ren;

    if (wen) begin
      wr_ptr_d = wr_ptr_q + ONE;
    end

    // Array read sees pre-edge contents, so a same-address write
    // in the full case returns the old word.
    if (ren) begin
      rd_ptr_d = rd_ptr_q + ONE;
      rdata_d  = mem_q[rd_ptr_q[AW-1:0]];
    end

    unique case (1'b1)
      (wen & ~ren): begin
        if (fill_q != FULL_LVL) fill_d = fill_q + ONE;
      end
      (ren & ~wen): begin
        if (fill_q != '0) fill_d = fill_q - ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule
